// File: rtl/aq_dtu_trig_bank.sv
// aq_dtu_trig_bank: bank of NUM_TRIG mcontrol-style address triggers with
// chaining, hit-count thresholds and an expt-pulse / held-halt handshake.
// Ports: forever_cpuclk/cpurst_b clock and async active-low reset;
//   cfg_wr/cfg_sel/cfg_ctrl/cfg_cnt/cfg_tdata2 per-trigger config write;
//   chk_vld/chk_type/chk_addr address check; dbg_on blocks matching;
//   halt_ack accepts halt_req; expt_req one-cycle pulse; trig_idx cause;
//   hit_vec sticky per-trigger action flags.
module aq_dtu_trig_bank #(
  parameter int NUM_TRIG = 4,
  parameter int ADDR_W   = 40,
  parameter int CNT_W    = 8,
  parameter int SEL_W    = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic                cfg_wr,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [7:0]          cfg_ctrl,
  input  logic [CNT_W-1:0]    cfg_cnt,
  input  logic [ADDR_W-1:0]   cfg_tdata2,
  input  logic                chk_vld,
  input  logic [1:0]          chk_type,
  input  logic [ADDR_W-1:0]   chk_addr,
  input  logic                dbg_on,
  input  logic                halt_ack,
  output logic                halt_req,
  output logic                expt_req,
  output logic [SEL_W-1:0]    trig_idx,
  output logic [NUM_TRIG-1:0] hit_vec
);

  localparam int CW1 = CNT_W + 1;

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]        ctrl_q  [NUM_TRIG];
  logic [CNT_W-1:0]  thr_q   [NUM_TRIG];
  logic [CNT_W-1:0]  cnt_q   [NUM_TRIG];
  logic [ADDR_W-1:0] tdata_q [NUM_TRIG];

  logic [NUM_TRIG-1:0] match;
  logic [NUM_TRIG-1:0] chain;
  logic [NUM_TRIG-1:0] fire;
  logic [NUM_TRIG-1:0] thr_met;
  logic [NUM_TRIG-1:0] wr_hit;
  logic [NUM_TRIG-1:0] act;

  logic             expt_d;
  logic [SEL_W-1:0] idx_d;

  // t ^ (t+1) marks the trailing ones plus the first zero: those bits
  // are don't-care in napot mode. All-ones wraps and matches everything.
  function automatic logic addr_hit(
    input logic [1:0]        mode,
    input logic [ADDR_W-1:0] t,
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] tp1;
    logic [ADDR_W-1:0] care;
    tp1  = t + ADDR_W'(1);
    care = ~(t ^ tp1);
    unique case (mode)
      2'd0:    addr_hit = (a == t);
      2'd1:    addr_hit = ((a ^ t) & care) == '0;
      2'd2:    addr_hit = (a >= t);
      default: addr_hit = (a < t);
    endcase
  endfunction

  always_comb begin
    logic             run;
    logic             pc;
    logic             found;
    logic             win_halt;
    logic [SEL_W-1:0] win;
    logic             type_ok;
    logic             idle;

    match    = '0;
    chain    = '0;
    fire     = '0;
    thr_met  = '0;
    wr_hit   = '0;
    act      = '0;
    run      = 1'b0;
    pc       = 1'b0;
    found    = 1'b0;
    win_halt = 1'b0;
    win      = '0;
    type_ok  = 1'b0;
    idle     = (state_q == S_IDLE);

    for (int i = 0; i < NUM_TRIG; i++) begin
      chain[i] = (i < NUM_TRIG - 1) ? ctrl_q[i][6] : 1'b0;
      type_ok  = (chk_type == 2'd0 && ctrl_q[i][1])
              || (chk_type == 2'd1 && ctrl_q[i][2])
              || (chk_type == 2'd2 && ctrl_q[i][3]);
      match[i] = ctrl_q[i][0] && type_ok && chk_vld
              && !dbg_on && idle
              && addr_hit(ctrl_q[i][5:4], tdata_q[i], chk_addr);
      wr_hit[i] = cfg_wr && (int'(cfg_sel) == i);
      thr_met[i] = ({1'b0, cnt_q[i]} + CW1'(1))
                >= {1'b0, thr_q[i]};
    end

    // run stays high only while every member of the current chain
    // group has matched; a group fires at its final member.
    for (int i = 0; i < NUM_TRIG; i++) begin
      run     = match[i] && (run || !pc);
      fire[i] = run && !chain[i];
      act[i]  = fire[i] && thr_met[i] && !wr_hit[i];
      pc      = chain[i];
    end

    for (int i = 0; i < NUM_TRIG; i++) begin
      if (act[i] && !found) begin
        found    = 1'b1;
        win      = SEL_W'(i);
        win_halt = ctrl_q[i][7];
      end
    end

    state_d = state_q;
    expt_d  = 1'b0;
    idx_d   = trig_idx;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d = win;
          if (win_halt) state_d = S_PEND;
          else          expt_d  = 1'b1;
        end
      end
      S_PEND: begin
        if (halt_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign halt_req = (state_q == S_PEND);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= S_IDLE;
      expt_req <= 1'b0;
      trig_idx <= '0;
      hit_vec  <= '0;
      for (int i = 0; i < NUM_TRIG; i++) begin
        ctrl_q[i]  <= '0;
        thr_q[i]   <= '0;
        cnt_q[i]   <= '0;
        tdata_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      expt_req <= expt_d;
      trig_idx <= idx_d;
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (wr_hit[i]) begin
          ctrl_q[i]  <= cfg_ctrl;
          thr_q[i]   <= cfg_cnt;
          tdata_q[i] <= cfg_tdata2;
          cnt_q[i]   <= '0;
          hit_vec[i] <= 1'b0;
        end else if (fire[i]) begin
          if (thr_met[i]) begin
            cnt_q[i]   <= '0;
            hit_vec[i] <= 1'b1;
          end else if (cnt_q[i] != '1) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/aq_dtu_trig_bank.md
# aq_dtu_trig_bank

Parametrised bank of NUM_TRIG mcontrol-style address triggers for the DTU, replacing the fixed two-trigger match path. Each cycle it compares an execute, store or load address against every enabled trigger. It supports four match modes, chaining of adjacent triggers, and a per-trigger hit-count threshold. It then issues either a one-cycle exception pulse or a held debug-halt request with an acknowledge handshake toward RTU.

## Interface
Parameters:
- NUM_TRIG, 4, number of triggers, 1..8
- ADDR_W, 40, compare width
- CNT_W, 8, hit-count threshold/counter width
- SEL_W, max(1,$clog2(NUM_TRIG)), trigger index width

Ports:
- forever_cpuclk  in  1  clock; single clock domain
- cpurst_b  in  1  asynchronous active-low reset
- cfg_wr  in  1  write config of trigger cfg_sel this cycle
- cfg_sel  in  SEL_W  target trigger; values >= NUM_TRIG are ignored
- cfg_ctrl  in  8  [0] en, [1] exe, [2] store, [3] load, [5:4] match (0 eq, 1 napot, 2 ge, 3 lt), [6] chain, [7] action (0 expt, 1 halt)
- cfg_cnt  in  CNT_W  hit threshold; 0 and 1 both mean fire on first hit
- cfg_tdata2  in  ADDR_W  compare value
- chk_vld  in  1  address check valid
- chk_type  in  2  0 exe, 1 store, 2 load, 3 none/never matches
- chk_addr  in  ADDR_W  address under check
- dbg_on  in  1  core in debug mode; suppresses all matching
- halt_ack  in  1  RTU accepted halt request
- halt_req  out  1  debug-halt request, held until ack
- expt_req  out  1  one-cycle breakpoint-exception pulse
- trig_idx  out  SEL_W  index of the trigger that caused the current halt_req/expt_req
- hit_vec  out  NUM_TRIG  sticky per-trigger action flag

## Operation
- Raw match[i] requires all of: en; the type bit for chk_type set; chk_vld; !dbg_on; FSM in IDLE.
- Match modes:
  - eq: addr == tdata2.
  - napot: let k = number of trailing ones of tdata2; compare bits [ADDR_W-1:k+1]; all-ones tdata2 matches every address.
  - ge: unsigned addr >= tdata2.
  - lt: unsigned addr < tdata2.
- Chaining:
  - A chain group is a maximal run i..j where chain=1 on i..j-1 and chain=0 on j.
  - The chain bit of trigger NUM_TRIG-1 is treated as 0.
  - The group fires only when every member matches in the same cycle.
  - Count, action and hit_vec belong to member j only; counters of non-final members never change.
- Count: cnt[j] increments on each group fire. The action occurs when cnt[j]+1 >= threshold, and cnt[j] then clears to 0. The counter saturates at all-ones.
- When several groups act in one cycle, the lowest j wins. Counters of the losing groups still clear, and their hit_vec bits still set.
- FSM states:
  - IDLE: a winning halt action goes to PEND and sets halt_req=1 and trig_idx. A winning expt action pulses expt_req and stays in IDLE.
  - PEND: halt_req held; all matching suppressed. halt_ack goes to IDLE, and halt_req drops the cycle after ack.
  - halt_ack while in IDLE is ignored.
- cfg_wr to trigger i:
  - loads ctrl/cnt/tdata2;
  - clears cnt[i] and hit_vec[i];
  - if it coincides with a fire of i, the write wins and i takes no action that cycle.
  - cfg_wr is accepted in any state.

## Timing
- Reset values: halt_req=0, expt_req=0, trig_idx=0, hit_vec=0, FSM=IDLE, all counters 0, all ctrl fields 0 (disabled), tdata2=0.
- chk_vld in cycle N gives halt_req/expt_req/trig_idx/hit_vec registered in N+1. Match logic is combinational from registered config.
- A config written in cycle N takes effect for checks in N+1.
- halt_ack in cycle M clears halt_req in M+1. A new check in M+1 can raise halt_req again in M+2.
- Reset asserted mid-PEND returns to IDLE immediately and drops halt_req asynchronously.
- dbg_on=1 blocks matching but does not clear halt_req.

## Test plan
- eq, exe, halt on trigger 2 with tdata2=0x80001000; exe check at that address in cycle N -> halt_req=1, trig_idx=2, hit_vec=4'b0100 in N+1; halt held until halt_ack, then low one cycle later.
- napot with tdata2=0x0000_2007 (k=3), store, expt: store checks at 0x2000 and 0x200F -> expt_req one-cycle pulse each; check at 0x2010 -> no pulse; a load check at 0x2000 -> no pulse.
- Chain 0->1, trigger 0 ge 0x1000, trigger 1 lt 0x2000, halt: load at 0x1800 -> halt_req, trig_idx=1, hit_vec=4'b0010; load at 0x2800 -> nothing.
- cnt=3 on an eq exe trigger: three matching checks -> action only on the third; fourth and fifth hits -> no action (counter at 2).
- Triggers 1 (halt) and 3 (expt) hit in the same cycle -> halt_req with trig_idx=1, no expt_req, hit_vec=4'b1010; further matches while in PEND -> ignored.
- cfg_wr to trigger 0 in the same cycle as a trigger-0 match -> no action, hit_vec[0]=0. Assert cpurst_b low during PEND -> halt_req=0 immediately.
